// File: rtl/branch_commit_unit_pkg.sv
// Core constants and shared types for the branch commit unit.
package branch_commit_unit_pkg;

    localparam int unsigned ROB_DEPTH      = 8;
    localparam int unsigned ROB_DEPTH_BITS = $clog2(ROB_DEPTH);
    localparam int unsigned ADDR_WIDTH     = 32;

    typedef enum logic [1:0] {
        BCU_NONE   = 2'd0,
        BCU_BRANCH = 2'd1,
        BCU_JR     = 2'd2
    } bcu_kind_e;

    typedef enum logic [1:0] {
        StEmpty    = 2'd0,
        StAlloc    = 2'd1,
        StResolved = 2'd2
    } bcu_state_e;

    typedef struct packed {
        bcu_kind_e              kind;
        bcu_state_e             state;
        logic                   taken;
        logic [ADDR_WIDTH-1:0]  target;
    } bcu_entry_t;

endpackage

// File: rtl/branch_commit_unit.sv
// Per-ROB-slot branch/JR tracking; reports committed branch outcomes and JR targets.
// Define BCU_RESOLVE_BYPASS_EN to let a same-tag resolve+commit retire without a stall.
module branch_commit_unit
    import branch_commit_unit_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned TAG_W = ROB_DEPTH_BITS,
    parameter int unsigned AW    = ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  logic [1:0]       alloc_kind_i,
    input  logic             res_valid_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic             res_taken_i,
    input  logic [AW-1:0]    res_target_i,
    input  logic             commit_valid_i,
    input  logic [TAG_W-1:0] commit_tag_i,
    input  logic             flush_i,
    output logic             commit_stall_o,
    output logic             valid_branch_o,
    output logic             branch_outcome_o,
    output logic             valid_jump_reg_o,
    output logic [AW-1:0]    jump_target_o,
    output logic             valid_commit_o,
    output logic [TAG_W:0]   pending_o,
    output logic             proto_err_o
);

    bcu_entry_t entries_q [DEPTH];
    bcu_entry_t entries_d [DEPTH];

    logic          valid_commit_q, valid_commit_d;
    logic          valid_branch_q, valid_branch_d;
    logic          branch_outcome_q, branch_outcome_d;
    logic          valid_jump_reg_q, valid_jump_reg_d;
    logic [AW-1:0] jump_target_q, jump_target_d;
    logic          proto_err_q, proto_err_d;

    bcu_entry_t    cmt_e;
    logic          bypass;
    logic          commit_ok;
    logic          err;
    logic          cm_taken;
    logic [AW-1:0] cm_target;
    logic [TAG_W:0] cnt;

    assign cmt_e = entries_q[commit_tag_i];

`ifdef BCU_RESOLVE_BYPASS_EN
    assign bypass = res_valid_i && (res_tag_i == commit_tag_i);
`else
    assign bypass = 1'b0;
`endif

    // Only an unresolved head can stall; a same-tag resolve may bypass it.
    assign commit_stall_o = commit_valid_i && (cmt_e.state == StAlloc) && !bypass;

    always_comb begin
        entries_d        = entries_q;
        err              = 1'b0;
        commit_ok        = 1'b0;
        cm_taken         = cmt_e.taken;
        cm_target        = cmt_e.target;
        valid_commit_d   = 1'b0;
        valid_branch_d   = 1'b0;
        valid_jump_reg_d = 1'b0;
        branch_outcome_d = branch_outcome_q;
        jump_target_d    = jump_target_q;
        proto_err_d      = proto_err_q;

        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            branch_outcome_d = 1'b0;
            jump_target_d    = '0;
        end else begin
            if (res_valid_i) begin
                if (entries_q[res_tag_i].state == StAlloc) begin
                    entries_d[res_tag_i].state  = StResolved;
                    entries_d[res_tag_i].taken  = res_taken_i;
                    entries_d[res_tag_i].target = res_target_i;
                end else begin
                    err = 1'b1;
                end
            end

            if (commit_valid_i) begin
                if (cmt_e.state == StEmpty) begin
                    err = 1'b1;
                end else if (!commit_stall_o) begin
                    commit_ok = 1'b1;
                    // An ALLOC head reaching here was bypassed by this cycle's resolve.
                    if (cmt_e.state == StAlloc) begin
                        cm_taken  = res_taken_i;
                        cm_target = res_target_i;
                    end
                    entries_d[commit_tag_i] = '0;
                end
            end

            // Evaluated after commit so a same-tag retire frees the slot first.
            if (alloc_valid_i) begin
                if (entries_d[alloc_tag_i].state == StEmpty) begin
                    entries_d[alloc_tag_i].kind   = bcu_kind_e'(alloc_kind_i);
                    entries_d[alloc_tag_i].state  =
                        (bcu_kind_e'(alloc_kind_i) == BCU_NONE) ? StResolved : StAlloc;
                    entries_d[alloc_tag_i].taken  = 1'b0;
                    entries_d[alloc_tag_i].target = '0;
                end else begin
                    err = 1'b1;
                end
            end

            valid_commit_d = commit_ok;
            if (commit_ok && (cmt_e.kind == BCU_BRANCH)) begin
                valid_branch_d   = 1'b1;
                branch_outcome_d = cm_taken;
            end
            if (commit_ok && (cmt_e.kind == BCU_JR)) begin
                valid_jump_reg_d = 1'b1;
                jump_target_d    = cm_target;
            end
            proto_err_d = proto_err_q | err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_commit_q   <= 1'b0;
            valid_branch_q   <= 1'b0;
            branch_outcome_q <= 1'b0;
            valid_jump_reg_q <= 1'b0;
            jump_target_q    <= '0;
            proto_err_q      <= 1'b0;
        end else begin
            entries_q        <= entries_d;
            valid_commit_q   <= valid_commit_d;
            valid_branch_q   <= valid_branch_d;
            branch_outcome_q <= branch_outcome_d;
            valid_jump_reg_q <= valid_jump_reg_d;
            jump_target_q    <= jump_target_d;
            proto_err_q      <= proto_err_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].state != StEmpty) begin
                cnt = cnt + {{TAG_W{1'b0}}, 1'b1};
            end
        end
    end

    assign pending_o        = cnt;
    assign valid_commit_o   = valid_commit_q;
    assign valid_branch_o   = valid_branch_q;
    assign branch_outcome_o = branch_outcome_q;
    assign valid_jump_reg_o = valid_jump_reg_q;
    assign jump_target_o    = jump_target_q;
    assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_branch_commit_unit.sv
// Self-checking bench for branch_commit_unit: directed scenarios plus randomized traffic
// compared against a slot-level behavioural model.
module tb_branch_commit_unit;
    import branch_commit_unit_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 3;
    localparam int unsigned AW    = 32;
`ifdef BCU_RESOLVE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid, res_valid, res_taken, commit_valid, flush;
    logic [TAG_W-1:0] alloc_tag, res_tag, commit_tag;
    logic [1:0]       alloc_kind;
    logic [AW-1:0]    res_target;
    logic             commit_stall, valid_branch, branch_outcome, valid_jump_reg;
    logic             valid_commit, proto_err;
    logic [AW-1:0]    jump_target;
    logic [TAG_W:0]   pending;

    always #5 clk = ~clk;

    branch_commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_valid_i    (alloc_valid),
        .alloc_tag_i      (alloc_tag),
        .alloc_kind_i     (alloc_kind),
        .res_valid_i      (res_valid),
        .res_tag_i        (res_tag),
        .res_taken_i      (res_taken),
        .res_target_i     (res_target),
        .commit_valid_i   (commit_valid),
        .commit_tag_i     (commit_tag),
        .flush_i          (flush),
        .commit_stall_o   (commit_stall),
        .valid_branch_o   (valid_branch),
        .branch_outcome_o (branch_outcome),
        .valid_jump_reg_o (valid_jump_reg),
        .jump_target_o    (jump_target),
        .valid_commit_o   (valid_commit),
        .pending_o        (pending),
        .proto_err_o      (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: slot status 0 = free, 1 = waiting for outcome, 2 = outcome known.
    int            m_state [DEPTH];
    int            m_kind  [DEPTH];
    bit            m_taken [DEPTH];
    logic [AW-1:0] m_tgt   [DEPTH];
    bit            e_vc, e_vb, e_bo, e_vj, e_perr;
    logic [AW-1:0] e_jt;
    bit            exp_stall, obs_stall;

    function automatic int model_pending();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_state[i] != 0) n++;
        return n;
    endfunction

    function automatic bit model_stall();
        if (!commit_valid || m_state[commit_tag] != 1) return 1'b0;
        return !(BYPASS && res_valid && res_tag == commit_tag);
    endfunction

    task automatic model_update();
        bit err = 1'b0;
        bit byp;
        int pre [DEPTH];
        if (!rst_n) begin
            foreach (m_state[i]) m_state[i] = 0;
            {e_vc, e_vb, e_bo, e_vj, e_perr} = '0;
            e_jt = '0;
            return;
        end
        if (flush) begin
            foreach (m_state[i]) m_state[i] = 0;
            {e_vc, e_vb, e_bo, e_vj} = '0;
            e_jt = '0;
            return;
        end
        pre = m_state;
        byp = BYPASS && commit_valid && res_valid && res_tag == commit_tag && pre[commit_tag] == 1;
        {e_vc, e_vb, e_vj} = '0;
        if (commit_valid) begin
            if (pre[commit_tag] == 0) err = 1'b1;
            else if (pre[commit_tag] == 2 || byp) begin
                e_vc = 1'b1;
                if (m_kind[commit_tag] == 1) begin
                    e_vb = 1'b1;
                    e_bo = byp ? res_taken : m_taken[commit_tag];
                end
                if (m_kind[commit_tag] == 2) begin
                    e_vj = 1'b1;
                    e_jt = byp ? res_target : m_tgt[commit_tag];
                end
                m_state[commit_tag] = 0;
            end
        end
        if (res_valid && !byp) begin
            if (pre[res_tag] == 1) begin
                m_state[res_tag] = 2;
                m_taken[res_tag] = res_taken;
                m_tgt[res_tag]   = res_target;
            end else err = 1'b1;
        end
        if (alloc_valid) begin
            if (m_state[alloc_tag] == 0) begin
                m_state[alloc_tag] = (alloc_kind == 2'd0) ? 2 : 1;
                m_kind[alloc_tag]  = int'(alloc_kind);
            end else err = 1'b1;
        end
        if (err) e_perr = 1'b1;
    endtask

    task automatic idle();
        {alloc_valid, res_valid, res_taken, commit_valid, flush} = '0;
        alloc_tag = '0; res_tag = '0; commit_tag = '0; alloc_kind = '0; res_target = '0;
    endtask

    // Samples the combinational stall mid-cycle, then advances one edge.
    task automatic tick();
        @(negedge clk);
        obs_stall = commit_stall;
        exp_stall = model_stall();
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b0; commit_valid = 1'b1; commit_tag = 3'd0;
        tick();
        n_checks++;
        if (obs_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", obs_stall);
        end
        n_checks++;
        if ({valid_commit, valid_branch, branch_outcome, valid_jump_reg, jump_target, pending,
             proto_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: vc=%b vb=%b bo=%b vj=%b jt=%h pend=%0d perr=%b want all 0",
                                valid_commit, valid_branch, branch_outcome, valid_jump_reg,
                                jump_target, pending, proto_err);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (pending !== 4'd0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: pend=%0d perr=%b want 0/0", pending, proto_err);
        end
    endtask

    task automatic test_branch_commit();
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 3'd3; alloc_kind = 2'd1;
        tick();
        n_checks++;
        if (pending !== 4'd1) begin
            n_fail++; $display("FAIL br_pending1: got %0d want 1", pending);
        end
        res_valid = 1'b1; res_tag = 3'd3; res_taken = 1'b1;
        tick();
        commit_valid = 1'b1; commit_tag = 3'd3;
        tick();
        n_checks++;
        if ({obs_stall, valid_commit, valid_branch, branch_outcome, valid_jump_reg} !== 5'b01110) begin
            n_fail++; $display("FAIL br_pulse: stall=%b vc=%b vb=%b bo=%b vj=%b want 0 1 1 1 0",
                                obs_stall, valid_commit, valid_branch, branch_outcome, valid_jump_reg);
        end
        n_checks++;
        if (pending !== 4'd0) begin
            n_fail++; $display("FAIL br_pending0: got %0d want 0", pending);
        end
        tick();
        n_checks++;
        if ({valid_commit, valid_branch, branch_outcome} !== 3'b001) begin
            n_fail++; $display("FAIL br_one_cycle: vc=%b vb=%b bo=%b want 0 0 1",
                                valid_commit, valid_branch, branch_outcome);
        end
    endtask

    task automatic test_jr_stall();
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 3'd5; alloc_kind = 2'd2;
        tick();
        commit_valid = 1'b1; commit_tag = 3'd5;
        tick();
        n_checks++;
        if (obs_stall !== 1'b1 || valid_commit !== 1'b0 || pending !== 4'd1) begin
            n_fail++; $display("FAIL jr_stall: stall=%b vc=%b pend=%0d want 1 0 1",
                                obs_stall, valid_commit, pending);
        end
        res_valid = 1'b1; res_tag = 3'd5; res_target = 32'h0040_0100;
        tick();
        commit_valid = 1'b1; commit_tag = 3'd5;
        tick();
        n_checks++;
        if (obs_stall !== 1'b0 || valid_jump_reg !== 1'b1 || valid_branch !== 1'b0 ||
            jump_target !== 32'h0040_0100) begin
            n_fail++; $display("FAIL jr_commit: stall=%b vj=%b vb=%b jt=%h want 0 1 0 00400100",
                                obs_stall, valid_jump_reg, valid_branch, jump_target);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 3'd2; alloc_kind = 2'd1;
        tick();
        res_valid = 1'b1; res_tag = 3'd2; res_taken = 1'b1;
        commit_valid = 1'b1; commit_tag = 3'd2;
        tick();
`ifdef BCU_RESOLVE_BYPASS_EN
        n_checks++;
        if (obs_stall !== 1'b0 || valid_branch !== 1'b1 || branch_outcome !== 1'b1 ||
            pending !== 4'd0) begin
            n_fail++; $display("FAIL same_bypass: stall=%b vb=%b bo=%b pend=%0d want 0 1 1 0",
                                obs_stall, valid_branch, branch_outcome, pending);
        end
`else
        n_checks++;
        if (obs_stall !== 1'b1 || valid_branch !== 1'b0 || pending !== 4'd1) begin
            n_fail++; $display("FAIL same_stall: stall=%b vb=%b pend=%0d want 1 0 1",
                                obs_stall, valid_branch, pending);
        end
        commit_valid = 1'b1; commit_tag = 3'd2;
        tick();
        n_checks++;
        if (obs_stall !== 1'b0 || valid_branch !== 1'b1 || branch_outcome !== 1'b1 ||
            proto_err !== 1'b0) begin
            n_fail++; $display("FAIL same_retry: stall=%b vb=%b bo=%b perr=%b want 0 1 1 0",
                                obs_stall, valid_branch, branch_outcome, proto_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0] a_tags [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        logic [2:0] r_tags [4] = '{3'd1, 3'd0, 3'd7, 3'd6};
        bit         r_tkn  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit         c_bo   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_tag = a_tags[i]; alloc_kind = 2'd1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_tag = r_tags[i]; res_taken = r_tkn[i];
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            commit_valid = 1'b1; commit_tag = a_tags[i];
            tick();
            n_checks++;
            if (valid_branch !== 1'b1 || branch_outcome !== c_bo[i]) begin
                n_fail++; $display("FAIL b2b_commit%0d: vb=%b bo=%b want 1 %b",
                                    i, valid_branch, branch_outcome, c_bo[i]);
            end
        end
        n_checks++;
        if (pending !== 4'd0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: pend=%0d perr=%b want 0 0", pending, proto_err);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_tag = 3'(i); alloc_kind = 2'(i % 3);
            tick();
        end
        n_checks++;
        if (pending !== 4'd8) begin
            n_fail++; $display("FAIL flush_full: pend=%0d want 8", pending);
        end
        flush = 1'b1; commit_valid = 1'b1; commit_tag = 3'd0;
        tick();
        n_checks++;
        if (valid_commit !== 1'b0 || valid_branch !== 1'b0 || valid_jump_reg !== 1'b0 ||
            pending !== 4'd0) begin
            n_fail++; $display("FAIL flush_clear: vc=%b vb=%b vj=%b pend=%0d want 0 0 0 0",
                                valid_commit, valid_branch, valid_jump_reg, pending);
        end
        res_valid = 1'b1; res_tag = 3'd4;
        tick();
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++; $display("FAIL flush_perr: got %b want 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 3'd1; alloc_kind = 2'd1;
        tick();
        alloc_valid = 1'b1; alloc_tag = 3'd2; alloc_kind = 2'd2;
        res_valid = 1'b1; res_tag = 3'd1; res_taken = 1'b1;
        tick();
        alloc_valid = 1'b1; alloc_tag = 3'd3; alloc_kind = 2'd1;
        res_valid = 1'b1; res_tag = 3'd2; res_target = 32'hdead_beef;
        tick();
        res_valid = 1'b1; res_tag = 3'd3; res_taken = 1'b1;
        tick();
        rst_n = 1'b0; commit_valid = 1'b1; commit_tag = 3'd1;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({valid_commit, valid_branch, branch_outcome, valid_jump_reg, jump_target, pending,
             proto_err} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: vc=%b vb=%b bo=%b vj=%b jt=%h pend=%0d perr=%b want all 0",
                                valid_commit, valid_branch, branch_outcome, valid_jump_reg,
                                jump_target, pending, proto_err);
        end
        commit_valid = 1'b1; commit_tag = 3'd2;
        tick();
        n_checks++;
        if (proto_err !== 1'b1 || valid_commit !== 1'b0 || valid_jump_reg !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stale: perr=%b vc=%b vj=%b want 1 0 0",
                                proto_err, valid_commit, valid_jump_reg);
        end
    endtask

    function automatic logic [2:0] pick(int st);
        int cand [$];
        for (int i = 0; i < DEPTH; i++) if (m_state[i] == st) cand.push_back(i);
        if (cand.size() == 0 || $urandom_range(0, 5) == 0) return 3'($urandom_range(0, 7));
        return 3'(cand[$urandom_range(0, cand.size() - 1)]);
    endfunction

    task automatic test_random();
        logic [AW+12:0] obs, exp;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            alloc_valid  = ($urandom_range(0, 2) != 0);
            alloc_tag    = pick(0);
            alloc_kind   = 2'($urandom_range(0, 2));
            res_valid    = ($urandom_range(0, 2) != 0);
            res_tag      = pick(1);
            res_taken    = 1'($urandom_range(0, 1));
            res_target   = $urandom();
            commit_valid = ($urandom_range(0, 2) != 0);
            commit_tag   = ($urandom_range(0, 3) == 0) ? pick(1) : pick(2);
            tick();
            obs = {obs_stall, valid_commit, valid_branch, branch_outcome, valid_jump_reg,
                   jump_target, pending, proto_err};
            exp = {exp_stall, e_vc, e_vb, e_bo, e_vj, e_jt, 4'(model_pending()), e_perr};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL random%0d: got stall,vc,vb,bo,vj,jt,pend,perr=%h want %h",
                                    n, obs, exp);
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_branch_commit();
        test_jr_stall();
        test_same_cycle();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
